// File: rtl/interrupt_controller_pkg.sv
// Shared encodings and vector constants for the interrupt controller.
// The optional NMI path is enabled by defining INTC_NMI_EN.
package interrupt_controller_pkg;

  localparam int unsigned VEC_W = 6;

  localparam logic [VEC_W-1:0] VEC_BASE_DEF = 6'h2D;
  localparam logic [VEC_W-1:0] NMI_VEC_DEF  = 6'h3E;
  localparam logic [VEC_W-1:0] RST_VEC      = 6'h3F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_ACK  = 2'b10
  } intc_state_e;

  // Index width that stays legal for a single source.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/interrupt_controller_prio_enc.sv
// Combinational highest-index-wins priority encoder over the eligible sources.
module intc_prio_enc #(
  parameter int unsigned N_SRC = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic [N_SRC-1:0] eligible,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (eligible[i]) begin
        valid = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered interrupt collector, arbiter and INTACK sequencer for the CPU.
// Define INTC_NMI_EN to build the non-maskable request path.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int unsigned      N_SRC    = 16,
  parameter logic [VEC_W-1:0] VEC_BASE = VEC_BASE_DEF,
  parameter logic [VEC_W-1:0] NMI_VEC  = NMI_VEC_DEF
) (
  input  logic             MCLK,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             nmi_in,
  input  logic             cfg_we,
  input  logic [N_SRC-1:0] cfg_wdata,
  input  logic [N_SRC-1:0] cfg_clr,
  input  logic             INTACK,
  output logic             NMI,
  output logic             INT,
  output logic [VEC_W-1:0] IntAddrLSBs,
  output logic [N_SRC-1:0] pending_o,
  output logic [N_SRC-1:0] enable_o
);

  localparam int unsigned IDX_W = idx_width(N_SRC);

  logic [N_SRC-1:0] irq_prev, pending, enable, irq_rise, svc_clr;
  logic             win_valid, any_win, svc, nmi_pend;
  logic [IDX_W-1:0] win_idx, cur_idx, cur_idx_n;
  logic [VEC_W-1:0] win_vec, vec_r, vec_n;
  logic             cur_nmi, cur_nmi_n, nmi_r, nmi_n, int_r, int_n;
  intc_state_e      state, state_n;

  assign irq_rise = irq_in & ~irq_prev;

  intc_prio_enc #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_prio (
    .eligible (pending & enable),
    .valid    (win_valid),
    .index    (win_idx)
  );

  assign any_win = nmi_pend | win_valid;
  assign win_vec = nmi_pend ? NMI_VEC : VEC_BASE + VEC_W'(win_idx);
  assign svc_clr = (svc && !cur_nmi) ? (N_SRC'(1) << cur_idx) : '0;

  // Hardware edges win over both software and serviced clears.
  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      irq_prev <= '0;
      pending  <= '0;
      enable   <= '0;
    end else begin
      irq_prev <= irq_in;
      pending  <= irq_rise | (pending & ~cfg_clr & ~svc_clr);
      if (cfg_we) enable <= cfg_wdata;
    end
  end

`ifdef INTC_NMI_EN
  logic nmi_prev;

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      nmi_prev <= 1'b0;
      nmi_pend <= 1'b0;
    end else begin
      nmi_prev <= nmi_in;
      nmi_pend <= (nmi_in & ~nmi_prev) | (nmi_pend & ~(svc & cur_nmi));
    end
  end
`else
  logic unused_nmi;
  assign unused_nmi = nmi_in;
  assign nmi_pend   = 1'b0;
`endif

  // Next-state and next-output logic for the request/acknowledge sequence.
  always_comb begin
    state_n   = state;
    nmi_n     = nmi_r;
    int_n     = int_r;
    vec_n     = vec_r;
    cur_idx_n = cur_idx;
    cur_nmi_n = cur_nmi;
    svc       = 1'b0;
    case (state)
      ST_IDLE: begin
        nmi_n = 1'b0;
        int_n = 1'b0;
        if (any_win) begin
          state_n   = ST_REQ;
          vec_n     = win_vec;
          nmi_n     = nmi_pend;
          int_n     = !nmi_pend;
          cur_idx_n = win_idx;
          cur_nmi_n = nmi_pend;
        end
      end
      ST_REQ: begin
        if (INTACK) begin
          svc     = 1'b1;
          nmi_n   = 1'b0;
          int_n   = 1'b0;
          state_n = ST_ACK;
        end else if (any_win) begin
          vec_n     = win_vec;
          nmi_n     = nmi_pend;
          int_n     = !nmi_pend;
          cur_idx_n = win_idx;
          cur_nmi_n = nmi_pend;
        end else begin
          nmi_n   = 1'b0;
          int_n   = 1'b0;
          state_n = ST_IDLE;
        end
      end
      ST_ACK: begin
        nmi_n = 1'b0;
        int_n = 1'b0;
        if (!INTACK) state_n = ST_IDLE;
      end
      default: begin
        nmi_n   = 1'b0;
        int_n   = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      nmi_r   <= 1'b0;
      int_r   <= 1'b0;
      vec_r   <= RST_VEC;
      cur_idx <= '0;
      cur_nmi <= 1'b0;
    end else begin
      state   <= state_n;
      nmi_r   <= nmi_n;
      int_r   <= int_n;
      vec_r   <= vec_n;
      cur_idx <= cur_idx_n;
      cur_nmi <= cur_nmi_n;
    end
  end

  assign NMI         = nmi_r;
  assign INT         = int_r;
  assign IntAddrLSBs = vec_r;
  assign pending_o   = pending;
  assign enable_o    = enable;

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Collects peripheral interrupt requests and one non-maskable source.
- Prioritises them and drives the CPU's NMI, INT and IntAddrLSBs inputs.
- Sequences the INTACK handshake and clears the serviced pending flag.
- Sits between the peripherals and the CPU. The vector it drives is combined in the CPU as {9'h1FF, IntAddrLSBs, 1'b0}.

Parameters:
- N_SRC, 16: number of maskable sources, 1..16.
- VEC_BASE, 6'h2D: IntAddrLSBs value for source 0. Source i uses VEC_BASE+i. VEC_BASE+N_SRC-1 must be below NMI_VEC.
- NMI_VEC, 6'h3E: IntAddrLSBs value for NMI, which gives address 0xFFFC.

Ports:
- MCLK, input, 1: master clock.
- reset, input, 1: asynchronous, active-low reset.
- irq_in, input, N_SRC: peripheral request lines, rising-edge triggered.
- nmi_in, input, 1: non-maskable request, rising-edge triggered.
- cfg_we, input, 1: write strobe for the enable mask.
- cfg_wdata, input, N_SRC: new enable mask.
- cfg_clr, input, N_SRC: software pending-clear, one-cycle pulses.
- INTACK, input, 1: interrupt acknowledge from the CPU.
- NMI, output, 1: NMI request to the CPU.
- INT, output, 1: maskable request to the CPU (the CPU gates it with GIE).
- IntAddrLSBs, output, 6: vector LSBs.
- pending_o, output, N_SRC: pending flags, for status readback.
- enable_o, output, N_SRC: enable mask.

Behaviour:
- Reset (reset low, asynchronous): pending=0, nmi_pend=0, enable=0, prev-sample regs=0, state=IDLE, NMI=0, INT=0, IntAddrLSBs=6'h3F. Outputs hold these values until the first rising MCLK after reset goes high.
- Edge detect: irq_prev and nmi_prev register the inputs each cycle. A rising edge is input&~prev. On that clock edge pending[i] (or nmi_pend) is set.
- Pending set and clear priority: a hardware set beats cfg_clr in the same cycle. cfg_clr clears any bit not being set. Serviced-clear and a new edge on the same source in the same cycle: set wins, so the source stays pending.
- Enable: cfg_we loads enable from cfg_wdata. A disabled source still latches pending but does not compete.
- Priority: NMI (nmi_pend) beats all maskable sources. Among eligible sources (pending&enable) the highest index wins.
- All outputs are registered. Latency from the input edge sampled at edge t: pending at t, INT/NMI/IntAddrLSBs valid after edge t+1.
- FSM state IDLE: NMI=INT=0.
  - If any eligible source or nmi_pend exists, go to REQ and load IntAddrLSBs = winner vector.
  - NMI=1 if the winner is NMI, else INT=1.
- FSM state REQ, INTACK low:
  - Re-arbitrate every cycle and update the vector and NMI/INT, so a higher-priority arrival pre-empts.
  - If no eligible winner remains (for example its enable was cleared), return to IDLE and drop NMI/INT.
  - IntAddrLSBs keeps its last value.
- FSM state REQ, INTACK high:
  - Freeze the vector and clear the pending bit (or nmi_pend) of the currently presented source.
  - Deassert NMI/INT and go to ACK.
- FSM state ACK: hold IntAddrLSBs stable while INTACK is high. When INTACK is low, go to IDLE. Arbitration resumes the next cycle, so back-to-back interrupts have at least 1 idle cycle.
- INTACK while in IDLE (spurious): ignored. No pending change, and the vector holds its last value.
- Reset asserted in any state: immediate return to reset values, with any in-flight acknowledge discarded.
- State encoding: IDLE=2'b00, REQ=2'b01, ACK=2'b10. 2'b11 is illegal and recovers to IDLE.

Optional Feature:
- Macro INTC_NMI_EN.
- Defined: nmi_in is edge-detected and prioritised as above.
- Undefined: nmi_in is ignored, nmi_pend is constant 0, NMI is tied 0, and the NMI arbitration logic is not built. The port remains for interface stability.

Decomposition:
- Shared parameter include (PARAMS.v): FSM state encodings, NMI_VEC, default VEC_BASE, reset vector value 6'h3F.
- One sub-module: intc_prio_enc. It is a combinational highest-index-wins encoder with inputs eligible[N_SRC] and outputs valid and index.
- Edge detect, pending/enable registers and the FSM stay in the top.

Test Plan:
- Reset, enable=16'h0001, pulse irq_in[0] -> INT=1 and IntAddrLSBs=6'h2D two cycles after the edge. INTACK high for 2 cycles -> INT drops, pending[0]=0, vector held at 6'h2D until INTACK falls.
- enable=16'hFFFF, edges on irq_in[3] and irq_in[9] in the same cycle -> vector 6'h36 (source 9). After its ack, one idle cycle, then vector 6'h30 (source 3).
- While in REQ for source 2, nmi_in edge arrives -> NMI=1, INT=0, vector 6'h3E before INTACK. After the ack, INT reasserts for source 2.
- irq_in[5] pending with enable[5]=0 -> INT stays 0 and pending_o[5]=1. Writing enable[5]=1 -> INT after 1 cycle. cfg_clr[5] pulsed together with a new edge on source 5 -> pending_o[5] stays 1.
- INTACK asserted in IDLE -> no state or pending change. reset pulsed low during ACK -> all outputs at reset values immediately, IntAddrLSBs=6'h3F.
- Build without INTC_NMI_EN -> nmi_in edges never raise NMI, and maskable behaviour is unchanged.
